// File: rtl/instruction_loader.sv
// Packs a UART byte stream (first byte = MSB) into instruction words and issues
// one-cycle writes to instruction memory until the HALT word or a full memory.
module instruction_loader #(
    parameter int                                WORD_SIZE_IN_BYTES = 4,
    parameter logic [8*WORD_SIZE_IN_BYTES-1:0]   HALT_INSTRUCTION   = 32'hFC000000,
    parameter int                                COUNT_SIZE         = 10
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic                            i_rx_valid,
    input  logic [7:0]                      i_rx_data,
    input  logic                            i_full_mem,
    output logic                            o_write_mem,
    output logic [8*WORD_SIZE_IN_BYTES-1:0] o_instruction,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_error,
    output logic [COUNT_SIZE-1:0]           o_word_count
);

    localparam int BUS_SIZE = 8 * WORD_SIZE_IN_BYTES;
    localparam int BCNT_W   = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(WORD_SIZE_IN_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECEIVE,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t              state;
    logic [BUS_SIZE-1:0] asm_word;
    logic [BCNT_W-1:0]   byte_cnt;
    logic [BUS_SIZE-1:0] next_asm;

    assign next_asm = {asm_word[BUS_SIZE-9:0], i_rx_data};

    // A restart in the WRITE cycle abandons the pending word, so the strobe is suppressed.
    assign o_write_mem = (state == WRITE) && !i_full_mem && !i_start;
    assign o_busy      = (state == RECEIVE) || (state == WRITE);
    assign o_done      = (state == DONE);
    assign o_error     = (state == ERROR);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            asm_word      <= '0;
            byte_cnt      <= '0;
            o_instruction <= '0;
            o_word_count  <= '0;
        end else if (i_start) begin
            state        <= RECEIVE;
            asm_word     <= '0;
            byte_cnt     <= '0;
            o_word_count <= '0;
        end else begin
            case (state)
                RECEIVE: begin
                    if (i_rx_valid) begin
                        asm_word <= next_asm;
                        if (byte_cnt == LAST_BYTE) begin
                            o_instruction <= next_asm;
                            byte_cnt      <= '0;
                            state         <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + BCNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (i_full_mem) begin
                        state <= ERROR;
                    end else begin
                        o_word_count <= o_word_count + COUNT_SIZE'(1);
                        if (o_instruction == HALT_INSTRUCTION) begin
                            state <= DONE;
                        end else begin
                            state <= RECEIVE;
                            // A byte landing in the write cycle starts the next word.
                            if (i_rx_valid) begin
                                asm_word <= next_asm;
                                byte_cnt <= BCNT_W'(1);
                            end
                        end
                    end
                end
                IDLE, DONE, ERROR: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomised and directed bench for instruction_loader: a byte-queue reference model
// predicts each memory write into a scoreboard that a negedge monitor drains.
module tb_instruction_loader;

    localparam int          CW   = 4;
    localparam logic [31:0] HALT = 32'hFC000000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          full = 1'b0;
    logic          write_mem;
    logic [31:0]   instruction;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] word_count;

    instruction_loader #(
        .WORD_SIZE_IN_BYTES(4),
        .HALT_INSTRUCTION  (HALT),
        .COUNT_SIZE        (CW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .i_full_mem   (full),
        .o_write_mem  (write_mem),
        .o_instruction(instruction),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]   word;
        logic [CW-1:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: 0 idle, 1 active, 2 done, 3 error
    int            m_mode = 0;
    logic [7:0]    m_bytes[$];
    bit            m_pending = 1'b0;
    logic [31:0]   m_word = '0;
    logic [31:0]   m_last = '0;
    logic [CW-1:0] m_count = '0;
    logic [7:0]    stream[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest predicted write.
    bit prev_wr = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (write_mem && prev_wr) begin
                checks++; errors++;
                $display("FAIL back_to_back_write at %0t", $time);
            end
            if (write_mem) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got %0h, expected no write", instruction);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_word", instruction, e.word);
                    chk("write_count", word_count, e.cnt);
                end
            end else if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_write: got none, expected %0h", e.word);
            end
        end
        prev_wr = write_mem;
    end

    task automatic cycle(input bit st, input bit v, input logic [7:0] d, input bit f);
        start = st; rx_valid = v; rx_data = d; full = f;
        if (m_pending && !f && !st) exp_q.push_back('{m_word, m_count});
        @(negedge clk);
        chk("busy", busy, (m_mode == 1));
        chk("done", done, (m_mode == 2));
        chk("error", error, (m_mode == 3));
        chk("count", word_count, m_count);
        chk("instr_hold", instruction, m_last);
        if (st) begin
            m_mode = 1; m_bytes.delete(); m_pending = 1'b0; m_count = '0;
        end else if (m_pending) begin
            m_pending = 1'b0;
            if (f) m_mode = 3;
            else begin
                m_count = m_count + 1'b1;
                if (m_word == HALT) m_mode = 2;
                else if (v) m_bytes.push_back(d);
            end
        end else if (m_mode == 1 && v) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_last = m_word;
                m_bytes.delete();
                m_pending = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) cycle(0, 1, w[8*i +: 8], 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_write"}, write_mem, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_count"}, word_count, 0);
        chk({tag, "_instr"}, instruction, 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        m_mode = 0; m_bytes.delete(); m_pending = 1'b0; m_count = '0; m_last = '0;
        start = 0; rx_valid = 0; full = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #3 check_all_zero("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle ignores bytes
        cycle(0, 1, 8'h55, 0);
        // Single word
        cycle(1, 0, 0, 0);
        send_word(32'h20080005);
        cycle(0, 0, 0, 0);
        // Three words ending in HALT, then ignored bytes
        cycle(1, 0, 0, 0);
        send_word(32'h20080005); cycle(0, 0, 0, 0);
        send_word(32'h00A01020); cycle(0, 0, 0, 0);
        send_word(HALT);         cycle(0, 0, 0, 0);
        send_word(32'h12345678); cycle(0, 0, 0, 0);
        chk("halt_done", done, 1);
        chk("halt_count", word_count, 3);
        // Memory full on the write cycle
        cycle(1, 0, 0, 0);
        send_word(32'h01020304); cycle(0, 0, 0, 0);
        cycle(0, 1, 8'hAA, 0); cycle(0, 1, 8'hBB, 0); cycle(0, 1, 8'hCC, 0);
        cycle(0, 1, 8'hDD, 1); cycle(0, 1, 8'hEE, 1); cycle(0, 0, 0, 0);
        chk("full_error", error, 1);
        chk("full_count", word_count, 1);
        // Partial word discarded by reset
        cycle(1, 0, 0, 0);
        cycle(0, 1, 8'h99, 0); cycle(0, 1, 8'h88, 0);
        do_reset();
        cycle(1, 0, 0, 0);
        send_word(32'h11223344); cycle(0, 0, 0, 0);
        // Byte in the write cycle begins the next word
        cycle(1, 0, 0, 0);
        send_word(32'h12345678);
        cycle(0, 1, 8'hAB, 0);
        cycle(0, 1, 8'hCD, 0); cycle(0, 1, 8'hEF, 0); cycle(0, 1, 8'h01, 0);
        cycle(0, 0, 0, 0);
        // Counter wraps modulo 2^CW
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 18; i++) send_word(32'h00010000 + i);
        cycle(0, 0, 0, 0);
        // Restart during a write cycle and mid-word
        send_word(32'hDEADBEEF);
        cycle(1, 1, 8'h77, 0);
        cycle(0, 1, 8'h01, 0); cycle(1, 1, 8'h02, 0);
        send_word(32'hCAFEF00D); cycle(0, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit st, v, f;
            logic [7:0] d;
            if (stream.size() == 0) begin
                logic [31:0] w;
                w = ($urandom % 6 == 0) ? HALT : 32'($urandom);
                for (int k = 3; k >= 0; k--) stream.push_back(w[8*k +: 8]);
            end
            st = (m_mode != 1) ? ($urandom % 6 == 0) : ($urandom % 300 == 0);
            v  = ($urandom % 3 != 0);
            d  = v ? stream.pop_front() : 8'($urandom);
            f  = ($urandom % 25 == 0);
            cycle(st, v, d, f);
        end
        cycle(0, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
